// File: rtl/cache_pkg.sv
// cache_pkg: shared state encodings, requester ids and defaults for the L2 port arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } arb_state_t;

    localparam logic [1:0] REQ_DREAD = 2'd0;
    localparam logic [1:0] REQ_IREAD = 2'd1;
    localparam logic [1:0] REQ_WB    = 2'd2;

    localparam int BURST_LEN_DEFAULT = 8;

endpackage

// File: rtl/counter_n.sv
// counter_n: modulo-n enable counter with sync clear; co flags the last count while enabled.
module counter_n #(
    parameter int n            = 8,
    parameter int counter_bits = 3
) (
    input  logic clk,
    input  logic r,
    input  logic en,
    output logic co
);

    logic [counter_bits-1:0] count;

    assign co = en && (count == counter_bits'(n - 1));

    always_ff @(posedge clk)
        count <= r ? '0 : en ? (co ? '0 : count + counter_bits'(1)) : count;

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the L2 port between D-refill, I-refill and write-buffer drain,
// round-robin with an urgent override for a full write buffer.
module l2_port_arbiter
    import cache_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int BEAT_BITS = 3,
    parameter int ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic                  wb_urgent,
    input  logic                  l2_ack,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_W-1:0]     l2_addr
);

    arb_state_t state;
    logic [1:0] rr_ptr;
    logic [1:0] winner;
    logic       last_beat;

    // Scan downwards so the first set bit at or after p is the one that sticks.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        rr_pick = p;
        for (int k = 2; k >= 0; k--)
            if (r[(int'(p) + k) % 3]) rr_pick = 2'((int'(p) + k) % 3);
    endfunction

    assign winner = (wb_urgent && req[REQ_WB]) ? REQ_WB : rr_pick(req, rr_ptr);

    counter_n #(.n(BURST_LEN), .counter_bits(BEAT_BITS)) u_beats (
        .clk (clk),
        .r   (reset || state != WRITE),
        .en  (l2_write),
        .co  (last_beat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            grant    <= 3'b000;
            done     <= 3'b000;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            l2_addr  <= '0;
        end else begin
            done <= 3'b000;
            case (state)
                IDLE: if (|req) begin
                    grant    <= 3'b001 << winner;
                    l2_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    l2_read  <= winner != REQ_WB;
                    l2_write <= winner == REQ_WB;
                    state    <= (winner == REQ_WB) ? WRITE : READ;
                    rr_ptr   <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
                end
                READ: if (l2_ack) begin
                    done    <= grant;
                    grant   <= 3'b000;
                    l2_read <= 1'b0;
                    state   <= IDLE;
                end
                WRITE: if (last_beat) begin
                    done     <= 3'b100;
                    grant    <= 3'b000;
                    l2_write <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    grant    <= 3'b000;
                    l2_read  <= 1'b0;
                    l2_write <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed scenarios plus random traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_l2_port_arbiter;

    localparam int BL = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    req = 3'b000;
    logic [3*AW-1:0] req_addr = '0;
    logic          wb_urgent = 1'b0;
    logic          l2_ack = 1'b0;
    logic [2:0]    grant, done;
    logic          l2_read, l2_write;
    logic [AW-1:0] l2_addr;

    l2_port_arbiter #(.BURST_LEN(BL), .BEAT_BITS(3), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .wb_urgent (wb_urgent),
        .l2_ack    (l2_ack),
        .grant     (grant),
        .done      (done),
        .l2_read   (l2_read),
        .l2_write  (l2_write),
        .l2_addr   (l2_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: current owner (-1 when idle), pointer, beats still owed, expected outputs.
    int          own = -1;
    int          ptr = 0;
    int          left = 0;
    logic [2:0]  e_grant = 0, e_done = 0;
    logic        e_read = 0, e_write = 0;
    logic [AW-1:0] e_addr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task model();
        int w;
        if (reset) begin
            own = -1; ptr = 0; left = 0;
            e_grant = 0; e_done = 0; e_read = 0; e_write = 0; e_addr = 0;
        end else begin
            e_done = 0;
            if (own < 0) begin
                if (req != 0) begin
                    w = -1;
                    if (wb_urgent && req[2]) w = 2;
                    for (int k = 0; k < 3; k++)
                        if (w < 0 && req[(ptr + k) % 3]) w = (ptr + k) % 3;
                    own = w;
                    ptr = (w + 1) % 3;
                    e_grant = 3'(1 << w);
                    e_addr = req_addr[w*AW +: AW];
                    e_read = (w != 2);
                    e_write = (w == 2);
                    left = BL;
                end
            end else if (own < 2) begin
                if (l2_ack) begin
                    e_done = 3'(1 << own);
                    e_grant = 0; e_read = 0; own = -1;
                end
            end else begin
                left--;
                if (left == 0) begin
                    e_done = 3'b100;
                    e_grant = 0; e_write = 0; own = -1;
                end
            end
        end
    endtask

    task step();
        @(posedge clk);
        model();
        #1;
        check("grant", 32'(grant), 32'(e_grant));
        check("done", 32'(done), 32'(e_done));
        check("l2_read", 32'(l2_read), 32'(e_read));
        check("l2_write", 32'(l2_write), 32'(e_write));
        check("l2_addr", l2_addr, e_addr);
        check("rd_wr_excl", 32'(l2_read && l2_write), 32'd0);
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("done_onehot0", 32'($onehot0(done)), 32'd1);
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Runs until the current owner finishes; returns how many l2_write cycles were seen.
    task automatic finish_txn(input logic auto_ack, input int ack_at, output int wcnt, output logic [2:0] dn);
        int cyc;
        wcnt = 0; dn = 0; cyc = 0;
        while (dn == 0 && cyc < 40) begin
            l2_ack = auto_ack || (cyc == ack_at);
            step();
            if (l2_write) wcnt++;
            dn = done;
            cyc++;
        end
        l2_ack = 1'b0;
        if (dn == 0) check("txn_timeout", 32'(cyc), 32'd0);
    endtask

    logic [2:0] seq [6];
    logic [2:0] exp_seq [6];
    logic [2:0] dn, prev;
    int wc, nseq, rdc, cyc;

    initial begin
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;

        // 1: reset with all requests pending
        req = 3'b111;
        for (int i = 0; i < 3; i++) set_addr(i, 32'h100 * (i + 1));
        repeat (3) begin
            step();
            check("rst_grant", 32'(grant), 32'd0);
        end
        reset = 1'b0;
        step();
        check("first_grant", 32'(grant), 32'b001);
        req = 3'b000;
        finish_txn(1'b1, -1, wc, dn);
        check("t1_done", 32'(dn), 32'b001);
        step();

        // 2: single D-refill, ack 5 cycles in
        req = 3'b001;
        set_addr(0, 32'h0000_1000);
        step();
        check("t2_grant", 32'(grant), 32'b001);
        check("t2_read", 32'(l2_read), 32'd1);
        check("t2_addr", l2_addr, 32'h0000_1000);
        finish_txn(1'b0, 4, wc, dn);
        check("t2_done", 32'(dn), 32'b001);
        req = 3'b000;
        step();
        check("t2_idle", 32'({grant, done}), 32'd0);

        // 3: write burst
        req = 3'b100;
        step();
        check("t3_grant", 32'(grant), 32'b100);
        wc = 1;
        finish_txn(1'b0, -1, cyc, dn);
        wc += cyc;
        check("t3_beats", 32'(wc), 32'd8);
        check("t3_done", 32'(dn), 32'b100);
        check("t3_grant_off", 32'(grant), 32'd0);
        req = 3'b000;
        step();

        // 4: all requesting, ack 2 cycles after each read grant
        req = 3'b111;
        nseq = 0; rdc = 0; prev = 0; cyc = 0;
        while (nseq < 6 && cyc < 200) begin
            l2_ack = l2_read && (rdc == 2);
            step();
            rdc = (grant != 0) ? rdc + 1 : 0;
            if (grant != 0 && prev == 0) begin
                seq[nseq] = grant;
                nseq++;
            end
            prev = grant;
            cyc++;
        end
        check("t4_count", 32'(nseq), 32'd6);
        for (int i = 0; i < 6; i++) check("t4_order", 32'(seq[i]), 32'(exp_seq[i]));
        req = 3'b000;
        if (grant != 0) finish_txn(1'b1, -1, wc, dn);
        step();

        // 5: rr_ptr=1 via a requester-0 read, then urgent write beats the pointer
        req = 3'b001;
        step();
        req = 3'b000;
        finish_txn(1'b1, -1, wc, dn);
        step();
        req = 3'b110;
        wb_urgent = 1'b1;
        step();
        check("t5_urgent", 32'(grant), 32'b100);
        wb_urgent = 1'b0;
        finish_txn(1'b0, 2, wc, dn);
        check("t5_beats", 32'(wc + 1), 32'd8);
        check("t5_done", 32'(dn), 32'b100);
        req = 3'b010;
        step();
        check("t5_next", 32'(grant), 32'b010);
        req = 3'b000;
        finish_txn(1'b1, -1, wc, dn);
        step();

        // 6: reset on write beat 4 aborts, then a fresh full burst
        req = 3'b100;
        repeat (4) step();
        check("t6_mid", 32'(l2_write), 32'd1);
        reset = 1'b1;
        step();
        check("t6_rst", 32'({grant, done, l2_read, l2_write}), 32'd0);
        reset = 1'b0;
        step();
        check("t6_regrant", 32'(grant), 32'b100);
        finish_txn(1'b0, -1, wc, dn);
        check("t6_beats", 32'(wc + 1), 32'd8);
        req = 3'b000;
        step();

        // Random traffic: requests held until done, occasional drops, resets, urgent and ack noise
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_addr(i, $urandom);
                end else if (req[i] && $urandom_range(0, 59) == 0) begin
                    req[i] = 1'b0;
                end
            end
            wb_urgent = ($urandom_range(0, 2) == 0);
            l2_ack = ($urandom_range(0, 2) == 0);
            step();
            req = req & ~e_done;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
